hdmi_rd_burst_ctrl: RTL and testbench

HDMI_RD_BURST_CTRL -- requirements
Module: hdmi_rd_burst_ctrl

---
 rtl/hdmi_rd_burst_ctrl.sv | 199 +++++++++++++++++++
 tb/tb_hdmi_rd_burst_ctrl.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/hdmi_rd_burst_ctrl.sv
// hdmi_rd_burst_ctrl: issues frame-buffer read bursts into a downstream pixel
// FIFO. It tracks FIFO occupancy and pixels remaining in the frame, restarts
// on every vsync rising edge, and flags FIFO underflow.
// Optional feature: define HDMI_RD_UNDERFLOW_CNT_EN to build the saturating
// 16-bit underflow event counter. Without it, O_Underflow_Cnt is tied to 0.
module hdmi_rd_burst_ctrl #(
  parameter int IMAGE_WIDTH = 1280,
  parameter int IMAGE_HIGH  = 1024,
  parameter int BURST_LEN   = 64,
  parameter int FIFO_DEPTH  = 512,
  parameter int FRAME_BASE  = 0,
  parameter int ADDR_W      = 28
) (
  input  logic                         Pixl_CLK,
  input  logic                         Rst_n,
  input  logic                         I_VGA_Sync,
  input  logic                         I_Pixel_Active,
  output logic                         O_Fifo_Flush,
  output logic                         O_Rd_Req,
  output logic [ADDR_W-1:0]            O_Rd_Addr,
  output logic [$clog2(BURST_LEN):0]   O_Rd_Len,
  input  logic                         I_Rd_Ack,
  input  logic                         I_Rd_Done,
  output logic                         O_Underflow,
  output logic [15:0]                  O_Underflow_Cnt
);

  localparam int LEN_W = $clog2(BURST_LEN) + 1;
  localparam int OCC_W = $clog2(FIFO_DEPTH) + 1;
  localparam int TOTAL = IMAGE_WIDTH * IMAGE_HIGH;
  localparam int REM_W = $clog2(TOTAL + 1);

  localparam logic [ADDR_W-1:0] BASE_A   = ADDR_W'(FRAME_BASE);
  localparam logic [REM_W-1:0]  TOTAL_R  = REM_W'(TOTAL);
  localparam logic [LEN_W-1:0]  BURST_L  = LEN_W'(BURST_LEN);
  localparam logic [OCC_W:0]    BURST_X  = (OCC_W + 1)'(BURST_LEN);
  localparam logic [OCC_W:0]    DEPTH_X  = (OCC_W + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    FLUSH = 3'd1,
    CHECK = 3'd2,
    REQ   = 3'd3,
    WAIT  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [1:0]         flush_cnt_q, flush_cnt_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [REM_W-1:0]   rem_q, rem_d;
  logic [OCC_W-1:0]   occ_q, occ_d;
  logic               pend_q, pend_d;
  logic               vs_q, vs_d;
  logic               uf_q, uf_d;

  logic               vs_edge;
  logic               ack_fire;
  logic               uf_evt;
  logic [OCC_W-1:0]   occ_tmp;

  // Next-state, burst bookkeeping and occupancy accounting
  always_comb begin
    state_d     = state_q;
    flush_cnt_d = flush_cnt_q;
    addr_d      = addr_q;
    len_d       = len_q;
    rem_d       = rem_q;
    pend_d      = pend_q;
    uf_d        = uf_q;
    vs_d        = I_VGA_Sync;
    vs_edge     = I_VGA_Sync & ~vs_q;
    ack_fire    = (state_q == REQ) & I_Rd_Ack;
    uf_evt      = 1'b0;
    occ_tmp     = occ_q;
    occ_d       = occ_q;

    case (state_q)
      IDLE: begin
        if (vs_edge) begin
          state_d     = FLUSH;
          flush_cnt_d = 2'd0;
        end
      end
      FLUSH: begin
        flush_cnt_d = flush_cnt_q + 2'd1;
        addr_d      = BASE_A;
        rem_d       = TOTAL_R;
        pend_d      = 1'b0;
        if (flush_cnt_q == 2'd3) state_d = CHECK;
      end
      CHECK: begin
        if (vs_edge) begin
          state_d     = FLUSH;
          flush_cnt_d = 2'd0;
        end else if (rem_q == '0) begin
          state_d = IDLE;
        end else if (({1'b0, occ_q} + BURST_X) <= DEPTH_X) begin
          state_d = REQ;
          // Last burst of the frame may be shorter than BURST_LEN
          if (int'(rem_q) < BURST_LEN) len_d = LEN_W'(rem_q);
          else                         len_d = BURST_L;
        end
      end
      REQ: begin
        if (vs_edge) pend_d = 1'b1;
        if (I_Rd_Ack) begin
          rem_d   = rem_q - REM_W'(len_q);
          addr_d  = addr_q + ADDR_W'({len_q, 1'b0});
          state_d = WAIT;
        end
      end
      WAIT: begin
        if (vs_edge) pend_d = 1'b1;
        // A pending frame restart waits for the in-flight burst to land
        if (I_Rd_Done) begin
          if (pend_q || vs_edge) begin
            state_d     = FLUSH;
            flush_cnt_d = 2'd0;
          end else begin
            state_d = CHECK;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    // Occupancy: credit the accepted burst first so a coincident pop nets len-1
    if (state_q == FLUSH) begin
      occ_d = '0;
      uf_d  = 1'b0;
    end else begin
      if (ack_fire) occ_tmp = occ_q + OCC_W'(len_q);
      occ_d = occ_tmp;
      if (I_Pixel_Active) begin
        if (occ_tmp != '0) begin
          occ_d = occ_tmp - 1'b1;
        end else begin
          uf_evt = 1'b1;
          uf_d   = 1'b1;
        end
      end
    end
  end

  // Control and bookkeeping registers with asynchronous reset
  always_ff @(posedge Pixl_CLK or negedge Rst_n) begin
    if (!Rst_n) begin
      state_q     <= IDLE;
      flush_cnt_q <= 2'd0;
      addr_q      <= BASE_A;
      len_q       <= '0;
      rem_q       <= '0;
      occ_q       <= '0;
      pend_q      <= 1'b0;
      vs_q        <= 1'b0;
      uf_q        <= 1'b0;
    end else begin
      state_q     <= state_d;
      flush_cnt_q <= flush_cnt_d;
      addr_q      <= addr_d;
      len_q       <= len_d;
      rem_q       <= rem_d;
      occ_q       <= occ_d;
      pend_q      <= pend_d;
      vs_q        <= vs_d;
      uf_q        <= uf_d;
    end
  end

`ifdef HDMI_RD_UNDERFLOW_CNT_EN
  logic [15:0] uf_cnt_q, uf_cnt_d;

  // Saturating underflow event count, cleared only by reset
  always_comb begin
    uf_cnt_d = uf_cnt_q;
    if (uf_evt && (uf_cnt_q != 16'hFFFF)) uf_cnt_d = uf_cnt_q + 16'd1;
  end

  // Underflow counter register
  always_ff @(posedge Pixl_CLK or negedge Rst_n) begin
    if (!Rst_n) uf_cnt_q <= 16'd0;
    else        uf_cnt_q <= uf_cnt_d;
  end

  assign O_Underflow_Cnt = uf_cnt_q;
`else
  assign O_Underflow_Cnt = 16'd0;
`endif

  // Request and flush decode straight from the state register so reset
  // removes them without waiting for a clock edge
  assign O_Rd_Req     = (state_q == REQ);
  assign O_Fifo_Flush = (state_q == FLUSH);
  assign O_Rd_Addr    = addr_q;
  assign O_Rd_Len     = len_q;
  assign O_Underflow  = uf_q;

endmodule

// File: tb/tb_hdmi_rd_burst_ctrl.sv
// Directed bench for hdmi_rd_burst_ctrl with a small 8x2 frame, 4-pixel bursts
// and an 8-pixel FIFO based at 0x100.
module tb_hdmi_rd_burst_ctrl;

  localparam int ADDR_W = 28;
  localparam int LEN_W  = 3;

  logic              clk;
  logic              rst_n;
  logic              vsync;
  logic              pop;
  logic              flush;
  logic              req;
  logic [ADDR_W-1:0] addr;
  logic [LEN_W-1:0]  len;
  logic              ack;
  logic              done;
  logic              uf;
  logic [15:0]       uf_cnt;

  int total = 0;
  int bad   = 0;
  int req_cnt = 0;
  logic prev_req = 1'b0;

`ifdef HDMI_RD_UNDERFLOW_CNT_EN
  localparam logic [15:0] EXP_UF_CNT = 16'd3;
`else
  localparam logic [15:0] EXP_UF_CNT = 16'd0;
`endif

  hdmi_rd_burst_ctrl #(
    .IMAGE_WIDTH(8),
    .IMAGE_HIGH (2),
    .BURST_LEN  (4),
    .FIFO_DEPTH (8),
    .FRAME_BASE (32'h100),
    .ADDR_W     (ADDR_W)
  ) dut (
    .Pixl_CLK       (clk),
    .Rst_n          (rst_n),
    .I_VGA_Sync     (vsync),
    .I_Pixel_Active (pop),
    .O_Fifo_Flush   (flush),
    .O_Rd_Req       (req),
    .O_Rd_Addr      (addr),
    .O_Rd_Len       (len),
    .I_Rd_Ack       (ack),
    .I_Rd_Done      (done),
    .O_Underflow    (uf),
    .O_Underflow_Cnt(uf_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock and sample 1 time unit after the edge
  task automatic tick();
    @(posedge clk);
    #1;
    if (req && !prev_req) req_cnt++;
    prev_req = req;
  endtask

  task automatic ack_cycle();
    ack = 1'b1;
    tick();
    ack = 1'b0;
  endtask

  // Done pulse arrives n cycles after the ack cycle
  task automatic done_after(input int n);
    repeat (n - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic wait_req(input string tag, input int maxc);
    int n;
    n = 0;
    while (!req && n < maxc) begin
      tick();
      n++;
    end
    chk(tag, {31'd0, req}, 32'd1);
  endtask

  initial begin
    int seen;
    rst_n = 1'b0; vsync = 1'b0; pop = 1'b0; ack = 1'b0; done = 1'b0;
    tick(); tick();
    rst_n = 1'b1;
    tick();

    // Reset state
    chk("rst_req",   {31'd0, req},   32'd0);
    chk("rst_flush", {31'd0, flush}, 32'd0);
    chk("rst_addr",  32'(addr),      32'h100);
    chk("rst_len",   32'(len),       32'd0);
    chk("rst_uf",    {31'd0, uf},    32'd0);
    chk("rst_ufcnt", 32'(uf_cnt),    32'd0);
    chk("rst_occ",   32'(dut.occ_q), 32'd0);

    // Vsync edge, four flush cycles, two bursts, then parked with FIFO full
    vsync = 1'b1;
    tick();
    for (int i = 0; i < 4; i++) begin
      chk("flush_on", {31'd0, flush}, 32'd1);
      chk("flush_noreq", {31'd0, req}, 32'd0);
      tick();
    end
    chk("flush_off", {31'd0, flush}, 32'd0);
    tick();
    chk("b1_req",  {31'd0, req}, 32'd1);
    chk("b1_addr", 32'(addr),    32'h100);
    chk("b1_len",  32'(len),     32'd4);
    ack_cycle();
    chk("b1_ackreq", {31'd0, req}, 32'd0);
    chk("b1_occ",    32'(dut.occ_q), 32'd4);
    done_after(3);
    tick();
    chk("b2_req",  {31'd0, req}, 32'd1);
    chk("b2_addr", 32'(addr),    32'h108);
    chk("b2_len",  32'(len),     32'd4);
    ack_cycle();
    chk("b2_occ", 32'(dut.occ_q), 32'd8);
    done_after(3);
    repeat (3) tick();
    chk("full_noreq", {31'd0, req}, 32'd0);
    chk("full_occ",   32'(dut.occ_q), 32'd8);

    // Draining to occupancy 4 allows the third burst
    pop = 1'b1;
    repeat (4) tick();
    chk("drain_occ",   32'(dut.occ_q), 32'd4);
    chk("drain_noreq", {31'd0, req}, 32'd0);
    pop = 1'b0;
    tick();
    chk("b3_req",  {31'd0, req}, 32'd1);
    chk("b3_addr", 32'(addr),    32'h110);
    chk("b3_occ",  32'(dut.occ_q), 32'd4);

    // Ack coincident with a pop at occupancy 4
    pop = 1'b1;
    ack_cycle();
    chk("ackpop_occ", 32'(dut.occ_q), 32'd7);
    tick(); tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("b3_done_occ", 32'(dut.occ_q), 32'd4);
    tick();
    chk("b4_req",  {31'd0, req}, 32'd1);
    chk("b4_addr", 32'(addr),    32'h118);
    chk("b4_occ",  32'(dut.occ_q), 32'd3);
    pop = 1'b0;
    ack_cycle();
    chk("b4_occ_ack", 32'(dut.occ_q), 32'd7);
    done_after(2);
    repeat (4) tick();
    chk("idle_noreq",   {31'd0, req},   32'd0);
    chk("idle_noflush", {31'd0, flush}, 32'd0);
    chk("req_total",    32'(req_cnt),   32'd4);

    // Underflow: drain 7, then three pops on an empty FIFO
    pop = 1'b1;
    repeat (7) tick();
    chk("empty_occ", 32'(dut.occ_q), 32'd0);
    chk("empty_uf",  {31'd0, uf},    32'd0);
    repeat (3) tick();
    pop = 1'b0;
    chk("uf_flag",  {31'd0, uf},    32'd1);
    chk("uf_occ",   32'(dut.occ_q), 32'd0);
    chk("uf_count", 32'(uf_cnt),    32'(EXP_UF_CNT));

    // New frame clears the flag but not the count
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    chk("f2_flush", {31'd0, flush}, 32'd1);
    repeat (4) tick();
    chk("f2_uf",    {31'd0, uf},    32'd0);
    chk("f2_ufcnt", 32'(uf_cnt),    32'(EXP_UF_CNT));
    wait_req("f2_b1_wait", 10);
    chk("f2_b1_addr", 32'(addr), 32'h100);
    ack_cycle();
    done_after(3);
    wait_req("f2_b2_wait", 10);
    chk("f2_b2_addr", 32'(addr), 32'h108);
    ack_cycle();

    // Vsync edge during WAIT defers the flush until done
    vsync = 1'b0;
    tick();
    vsync = 1'b1;
    tick();
    tick();
    chk("pend_noreq",   {31'd0, req},   32'd0);
    chk("pend_noflush", {31'd0, flush}, 32'd0);
    done = 1'b1;
    tick();
    done = 1'b0;
    chk("pend_flush", {31'd0, flush}, 32'd1);
    wait_req("pend_req_wait", 10);
    chk("pend_addr", 32'(addr),      32'h100);
    chk("pend_occ",  32'(dut.occ_q), 32'd0);

    // Reset while requesting drops the request immediately
    #2;
    rst_n = 1'b0;
    vsync = 1'b0;
    #1;
    chk("arst_req",  {31'd0, req},   32'd0);
    chk("arst_addr", 32'(addr),      32'h100);
    chk("arst_len",  32'(len),       32'd0);
    chk("arst_occ",  32'(dut.occ_q), 32'd0);
    tick();
    rst_n = 1'b1;
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (req || flush) seen++;
    end
    chk("post_rst_quiet", 32'(seen), 32'd0);
    vsync = 1'b1;
    tick();
    chk("post_rst_flush", {31'd0, flush}, 32'd1);
    wait_req("post_rst_wait", 10);
    chk("post_rst_addr", 32'(addr), 32'h100);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
